// File: rtl/core_tx_pkt_buffer.sv
// Per-core transmit packet buffer: stores whole packets from a core and forwards them to one arbiter input.
// Optional statistics outputs (tx_pkt_cnt, tx_word_cnt) are enabled by defining CORE_TX_STATS_EN.
module core_tx_pkt_buffer #(
  parameter int DEPTH_LOG2    = 9,
  parameter int MAX_PKT_WORDS = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] in_data,
  input  logic        in_wr,
  input  logic        in_eop,
  output logic        in_rdy,
  output logic        ovf_err,
  output logic [63:0] out_data,
  output logic        out_wr,
  output logic        out_req,
  input  logic        out_ack,
  output logic        out_bop,
  output logic        out_eop,
  input  logic        out_rdy
`ifdef CORE_TX_STATS_EN
  ,
  output logic [31:0] tx_pkt_cnt,
  output logic [31:0] tx_word_cnt
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW:0] MAX_WORDS = (PW + 1)'(MAX_PKT_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW-1:0] pkt_cnt_reg;
  logic          first_flag_reg;
  logic          ovf_err_reg;

  logic [64:0]   mem [DEPTH];
  logic [64:0]   rd_word;
  logic [PW-1:0] used;
  logic [PW-1:0] free;
  logic          full;
  logic          empty;
  logic          wr_en;
  logic          rd_eop;
  logic          pkt_inc;
  logic          pkt_dec;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign used  = wr_ptr_reg - rd_ptr_reg;
  assign free  = PW'(DEPTH) - used;
  assign full  = (used == PW'(DEPTH));
  assign empty = (used == '0);
  assign wr_en = in_wr & ~full;

  assign in_rdy  = ({1'b0, free} >= MAX_WORDS);
  assign ovf_err = ovf_err_reg;

  // Zero-latency read of the head word.
  assign rd_word  = mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
  assign out_data = rd_word[63:0];
  assign rd_eop   = rd_word[64];
  assign out_eop  = out_wr & rd_eop;
  assign out_bop  = out_wr & first_flag_reg;

  assign pkt_inc = wr_en & in_eop;
  assign pkt_dec = out_wr & rd_eop;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= {in_eop, in_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      pkt_cnt_reg    <= '0;
      first_flag_reg <= 1'b1;
      ovf_err_reg    <= 1'b0;
      state_reg      <= ST_IDLE;
    end else begin
      state_reg <= state_next;
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (in_wr && full) begin
        ovf_err_reg <= 1'b1;
      end
      if (out_wr) begin
        rd_ptr_reg     <= rd_ptr_reg + 1'b1;
        first_flag_reg <= rd_eop;
      end
      case ({pkt_inc, pkt_dec})
        2'b10:   pkt_cnt_reg <= pkt_cnt_reg + 1'b1;
        2'b01:   pkt_cnt_reg <= pkt_cnt_reg - 1'b1;
        default: pkt_cnt_reg <= pkt_cnt_reg;
      endcase
    end
  end

  // Only complete packets are counted, so a started packet never underruns.
  always_comb begin
    state_next = state_reg;
    out_req    = 1'b0;
    out_wr     = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (pkt_cnt_reg != '0) begin
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        out_req = 1'b1;
        if (out_ack) begin
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        out_req = 1'b1;
        out_wr  = out_ack & out_rdy & ~empty;
        if (out_wr && rd_eop) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // One cycle with req low lets the arbiter rotate to the other input.
        state_next = (pkt_cnt_reg != '0) ? ST_REQ : ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

`ifdef CORE_TX_STATS_EN
  logic [31:0] tx_pkt_cnt_reg, tx_word_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_pkt_cnt_reg  <= '0;
      tx_word_cnt_reg <= '0;
    end else if (out_wr) begin
      tx_word_cnt_reg <= tx_word_cnt_reg + 32'd1;
      if (rd_eop) begin
        tx_pkt_cnt_reg <= tx_pkt_cnt_reg + 32'd1;
      end
    end
  end

  assign tx_pkt_cnt  = tx_pkt_cnt_reg;
  assign tx_word_cnt = tx_word_cnt_reg;
`endif

endmodule

// File: tb/tb_core_tx_pkt_buffer.sv
// Scoreboard bench for core_tx_pkt_buffer: drivers queue expected words, a negedge monitor checks them.
module tb_core_tx_pkt_buffer;

  localparam int DL2   = 4;
  localparam int MAXW  = 4;
  localparam int DEPTH = 1 << DL2;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic        in_wr;
  logic        in_eop;
  logic        in_rdy;
  logic        ovf_err;
  logic [63:0] out_data;
  logic        out_wr;
  logic        out_req;
  logic        out_ack;
  logic        out_bop;
  logic        out_eop;
  logic        out_rdy;
`ifdef CORE_TX_STATS_EN
  logic [31:0] tx_pkt_cnt;
  logic [31:0] tx_word_cnt;
`endif

  core_tx_pkt_buffer #(.DEPTH_LOG2(DL2), .MAX_PKT_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_wr(in_wr), .in_eop(in_eop), .in_rdy(in_rdy), .ovf_err(ovf_err),
    .out_data(out_data), .out_wr(out_wr), .out_req(out_req), .out_ack(out_ack),
    .out_bop(out_bop), .out_eop(out_eop), .out_rdy(out_rdy)
`ifdef CORE_TX_STATS_EN
    , .tx_pkt_cnt(tx_pkt_cnt), .tx_word_cnt(tx_word_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  logic [65:0] exp_q[$];      // {bop, eop, data}
  int model_used = 0;
  bit model_ovf  = 0;
  bit prev_eop   = 0;
  int pkts_since_rst  = 0;
  int words_since_rst = 0;
  int sent_total = 0;
  bit ack_en    = 1;
  bit rand_mode = 0;
  logic req_d = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Arbiter model: grant follows request one cycle later.
  always @(negedge clk) req_d = out_req;
  always @(posedge clk) begin
    #1;
    out_ack = ack_en && req_d && (!rand_mode || ($urandom_range(0, 3) != 0));
    out_rdy = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor: occupancy model plus in-order packet scoreboard.
  always @(negedge clk) begin
    logic [65:0] e;
    bit acc;
    if (reset) begin
      model_used = 0;
      model_ovf = 0;
      prev_eop = 0;
      pkts_since_rst = 0;
      words_since_rst = 0;
    end else begin
      chk("in_rdy", 64'(in_rdy), 64'((DEPTH - model_used) >= MAXW));
      chk("ovf_err", 64'(ovf_err), 64'(model_ovf));
      if (prev_eop) chk("req_low_after_eop", 64'(out_req), 64'd0);
      if (out_wr) begin
        chk("wr_handshake", 64'({out_req, out_ack, out_rdy}), 64'h7);
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_word actual=%h required=none", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e[63:0]);
          chk("out_bop", 64'(out_bop), 64'(e[65]));
          chk("out_eop", 64'(out_eop), 64'(e[64]));
        end
        words_since_rst++;
        sent_total++;
        if (out_eop) pkts_since_rst++;
      end
      prev_eop = out_wr && out_eop;
      acc = in_wr && (model_used < DEPTH);
      if (in_wr && !acc) model_ovf = 1;
      model_used = model_used + int'(acc) - int'(out_wr);
    end
  end

  task automatic wait_rdy();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_rdy && n < 1000);
    if (!in_rdy) begin
      checks++;
      fails++;
      $display("FAIL in_rdy_timeout actual=0 required=1");
    end
  endtask

  task automatic write_pkt(input int len, input bit respect);
    logic [63:0] d;
    if (respect) wait_rdy();
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      #1;
      d = {$urandom, $urandom};
      in_wr = 1'b1;
      in_eop = (i == len - 1);
      in_data = d;
      exp_q.push_back({(i == 0), (i == len - 1), d});
    end
    @(posedge clk);
    #1;
    in_wr = 1'b0;
    in_eop = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout actual=%0d required=0 words left", exp_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_stats();
`ifdef CORE_TX_STATS_EN
    chk("tx_pkt_cnt", 64'(tx_pkt_cnt), 64'(pkts_since_rst));
    chk("tx_word_cnt", 64'(tx_word_cnt), 64'(words_since_rst));
`endif
  endtask

  initial begin
    int base;
    int n;
    logic [63:0] d;
    reset = 1'b1;
    in_wr = 1'b0;
    in_eop = 1'b0;
    in_data = '0;
    out_ack = 1'b0;
    out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_req", 64'(out_req), 64'd0);
    chk("rst_out_wr", 64'(out_wr), 64'd0);
    chk("rst_out_bop", 64'(out_bop), 64'd0);
    chk("rst_out_eop", 64'(out_eop), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("rst_ovf_err", 64'(ovf_err), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 4-word packet, then two 1-word packets back to back.
    write_pkt(4, 1);
    wait_drain(200);
    write_pkt(1, 1);
    write_pkt(1, 1);
    wait_drain(200);

    // Fill with no grant: 16 words fit, the 17th is dropped.
    ack_en = 0;
    for (int i = 0; i < 17; i++) begin
      @(posedge clk);
      #1;
      d = {$urandom, $urandom};
      in_wr = 1'b1;
      in_eop = (i % 4 == 3) || (i == 16);
      in_data = d;
      if (i < 16) exp_q.push_back({(i % 4 == 0), (i % 4 == 3), d});
    end
    @(posedge clk);
    #1;
    in_wr = 1'b0;
    in_eop = 1'b0;
    @(negedge clk);
    chk("full_ovf_err", 64'(ovf_err), 64'd1);
    chk("full_in_rdy", 64'(in_rdy), 64'd0);
    base = sent_total;
    ack_en = 1;
    wait_drain(400);
    chk("full_sent_words", 64'(sent_total - base), 64'd16);
    do_reset();

    // Reset in the middle of a 10-word packet.
    base = sent_total;
    write_pkt(10, 0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((sent_total - base) < 3 && n < 200);
    chk("mid_send_progress", 64'(sent_total - base >= 3), 64'd1);
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_out_req", 64'(out_req), 64'd0);
    chk("mid_rst_out_wr", 64'(out_wr), 64'd0);
    chk("mid_rst_in_rdy", 64'(in_rdy), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    write_pkt(2, 1);
    wait_drain(200);

    // Statistics over packets of 3, 1 and 5 words.
    do_reset();
    write_pkt(3, 1);
    write_pkt(1, 1);
    write_pkt(5, 1);
    wait_drain(400);
    chk("stat_pkts_model", 64'(pkts_since_rst), 64'd3);
    chk("stat_words_model", 64'(words_since_rst), 64'd9);
    check_stats();

    // Randomized traffic with random grant and ready stalls.
    rand_mode = 1;
    for (int p = 0; p < 40; p++) begin
      write_pkt($urandom_range(1, MAXW), 1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_drain(3000);
    rand_mode = 0;
    check_stats();
    chk("final_ovf_err", 64'(ovf_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
